io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Arbitrates the single memory-mapped IO port (io_we/io_addr/io_data/io_read_data) between two requesters: m0 (CPU load/store stage) and m1 (debug/loader engine).
- Sequences each access as one grant, one access phase and one completion pulse.
- Guarantees io_we is high for exactly one cycle per write, so queued IO targets (segment VRAM push, LED, blink) see exactly one write event per transaction.
- Includes round-robin fairness and an access timeout.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max ACCESS-state cycles waiting for io_ready before abort (1..2^16-1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
m0_req  in  1  m0 request; held with m0_we/m0_addr/m0_wdata until m0_gnt
m0_we  in  1  1 = write, 0 = read
m0_addr  in  AW  m0 target address
m0_wdata  in  DW  m0 write data
m0_gnt  out  1  one-cycle pulse: m0 request latched
m0_done  out  1  one-cycle pulse: m0 access complete
m0_rdata  out  DW  read data, valid while m0_done=1, held until next m0 completion
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata  same as m0 for requester 1
io_we  out  1  write strobe to IO block
io_addr  out  AW  IO address
io_data  out  DW  IO write data
io_read_data  in  DW  IO read data (combinational from io_addr)
io_ready  in  1  target ready; tie 1 for zero-wait targets
err  out  1  one-cycle pulse alongside mX_done when the access timed out

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; last_owner=1 (so m0 wins first tie).
  - All outputs 0; latched req regs 0; timeout counter 0.
  - An in-flight access is dropped with no done pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Neither request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester != last_owner.
  - On grant: latch owner, we, addr, wdata; assert owner's gnt for the next cycle; set last_owner=owner; go to ACCESS; clear counter.
- ACCESS:
  - io_addr/io_data driven from latched regs.
  - io_we = latched_we AND io_ready (combinational gate); one cycle max, because the state exits on that cycle.
  - io_ready=1: capture io_read_data into owner's rdata (reads only; writes leave rdata unchanged); go to DONE.
  - io_ready=0: counter++. When counter == TIMEOUT-1 with io_ready still 0: owner rdata=0, flag err, go to DONE; io_we never asserted.
- DONE:
  - Owner's done=1 (and err if flagged) for one cycle; io_* outputs 0; return to IDLE.
- Outside ACCESS: io_we=0, io_addr=0, io_data=0.
- Latency with io_ready=1: req seen in IDLE at cycle N -> gnt and ACCESS at N+1 -> done at N+2. Minimum 3 cycles per transaction; back-to-back requests re-arbitrate at N+3.
- Requests are sampled only in IDLE. A req still high in IDLE after done is a new transaction; the requester must drop req in the gnt cycle to avoid a repeat.
- Requester inputs changing after gnt have no effect on the current access.
- gnt and done are never asserted to both requesters in the same cycle.

Test Plan:
- m0 write, addr=0xFFFFFC60, data=0x00123456, io_ready=1 -> m0_gnt at N+1; io_we=1 for exactly one cycle with io_addr/io_data matching; m0_done at N+2; err=0.
- m0 and m1 both hold req continuously after reset -> grants alternate m0, m1, m0, m1; each done 3 cycles apart; no cycle with both gnt.
- m1 read, addr=0xFFFFFC70, io_read_data=0x000000A5 -> m1_rdata=0x000000A5 at m1_done and held afterward; io_we stays 0.
- io_ready low for 3 cycles during m0 write -> io_we low while stalled, high for exactly one cycle when ready rises; done follows the next cycle.
- TIMEOUT=8, io_ready held 0 -> after 8 ACCESS cycles: m0_done=1, err=1, m0_rdata=0; io_we never asserted.
- rst pulled low mid-ACCESS -> all outputs 0 immediately, no done pulse; after release, a pending m0 and m1 tie grants m0 first.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the single memory-mapped IO port.
// Each access runs IDLE -> ACCESS -> DONE with round-robin tie-breaking and an io_ready timeout.
module io_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,

    output logic          io_we,
    output logic [AW-1:0] io_addr,
    output logic [DW-1:0] io_data,
    input  logic [DW-1:0] io_read_data,
    input  logic          io_ready,

    output logic          err,
    output logic [1:0]    dbg_state
);

    // Handshake: a requester raises mX_req with we/addr/wdata stable and holds them until
    // mX_gnt pulses; the request is captured on that edge and later inputs are ignored.
    // mX_done pulses once when the access ends, with mX_rdata valid (and err on timeout).

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;

    logic          owner;
    logic          last_owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [15:0]   count;

    logic          any_req;
    logic          pick;
    logic          grant_fire;
    logic          in_access;
    logic          timeout_hit;
    logic          done_fire;

    // Arbitration: a lone requester wins; on a tie the one that did not win last time wins.
    always_comb begin
        any_req = m0_req | m1_req;
        pick    = 1'b0;
        if (m0_req && m1_req) begin
            pick = ~last_owner;
        end else if (m1_req) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        grant_fire  = (state == IDLE) && any_req;
        in_access   = (state == ACCESS);
        timeout_hit = in_access && !io_ready && (count == TO_LAST);
        done_fire   = in_access && (io_ready || timeout_hit);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (io_ready || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture and the ACCESS wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            count      <= '0;
        end else if (grant_fire) begin
            owner      <= pick;
            last_owner <= pick;
            lat_we     <= pick ? m1_we    : m0_we;
            lat_addr   <= pick ? m1_addr  : m0_addr;
            lat_wdata  <= pick ? m1_wdata : m0_wdata;
            count      <= '0;
        end else if (in_access && !io_ready && !timeout_hit) begin
            count <= count + 16'd1;
        end
    end

    // Response pulses and per-requester read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            err      <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_gnt  <= grant_fire && !pick;
            m1_gnt  <= grant_fire && pick;
            m0_done <= done_fire && !owner;
            m1_done <= done_fire && owner;
            err     <= timeout_hit;
            if (done_fire) begin
                // A timed-out access returns zero; a completed write leaves rdata alone.
                if (timeout_hit) begin
                    if (owner) begin
                        m1_rdata <= '0;
                    end else begin
                        m0_rdata <= '0;
                    end
                end else if (!lat_we) begin
                    if (owner) begin
                        m1_rdata <= io_read_data;
                    end else begin
                        m0_rdata <= io_read_data;
                    end
                end
            end
        end
    end

    // io_we is gated by io_ready so the strobe can only coincide with the ACCESS exit cycle.
    always_comb begin
        io_we   = 1'b0;
        io_addr = '0;
        io_data = '0;
        if (in_access) begin
            io_we   = lat_we & io_ready;
            io_addr = lat_addr;
            io_data = lat_wdata;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed vector table, hand-written corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_io_bus_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    logic          clk;
    logic          rst;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_done, m1_done;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_data;
    logic [DW-1:0] io_read_data;
    logic          io_ready;
    logic          err;
    logic [1:0]    dbg_state;

    // Requester-side pending transactions driven onto the DUT.
    logic          pend [2];
    logic          p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];

    assign m0_req   = pend[0];
    assign m1_req   = pend[1];
    assign m0_we    = p_we[0];
    assign m1_we    = p_we[1];
    assign m0_addr  = p_addr[0];
    assign m1_addr  = p_addr[1];
    assign m0_wdata = p_data[0];
    assign m1_wdata = p_data[1];

    // IO target model: read data is a pure function of the address.
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        if (a == 32'hFFFF_FC70) return 32'h0000_00A5;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign io_read_data = rd_of(io_addr);

    io_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_gnt       (m0_gnt),
        .m0_done      (m0_done),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_gnt       (m1_gnt),
        .m1_done      (m1_done),
        .m1_rdata     (m1_rdata),
        .io_we        (io_we),
        .io_addr      (io_addr),
        .io_data      (io_data),
        .io_read_data (io_read_data),
        .io_ready     (io_ready),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    int            last_own_m;
    logic [DW-1:0] exp_rd [2];
    int            stall;
    int            done_cyc;

    // Scoreboard of IO writes expected to be strobed, as {addr, data}.
    logic [AW+DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst && io_we) begin
            if (exp_q.size() == 0) begin
                check("io_we_unexpected", 64'(io_we), 64'd0);
            end else begin
                check("io_write", {io_addr, io_data}, exp_q.pop_front());
            end
        end
        if (rst) begin
            check("gnt_exclusive", 64'(m0_gnt & m1_gnt), 64'd0);
            check("done_exclusive", 64'(m0_done & m1_done), 64'd0);
        end
    end

    // Serves one transaction starting in an IDLE cycle (called just after a rising edge).
    task automatic serve_one(input bit keep, output int own, output logic o_err, output logic [31:0] o_rd);
        int            w;
        int            k;
        bit            to;
        bit            last;
        logic          t_we;
        logic [AW-1:0] t_addr;
        logic [DW-1:0] t_data;
        if (pend[0] && pend[1]) w = (last_own_m == 0) ? 1 : 0;
        else if (pend[1])       w = 1;
        else                    w = 0;
        to     = (stall >= TIMEOUT);
        t_we   = p_we[w];
        t_addr = p_addr[w];
        t_data = p_data[w];
        own    = 0;

        @(negedge clk);
        check("idle_gnt", {m0_gnt, m1_gnt}, 64'd0);
        check("idle_io", {io_we, io_addr}, 64'd0);
        check("idle_done", {m0_done, m1_done, err}, 64'd0);
        if (t_we && !to) exp_q.push_back({t_addr, t_data});

        k    = 0;
        last = 1'b0;
        while (!last) begin
            k++;
            @(posedge clk);
            #1;
            io_ready = (k > stall);
            if (k == 1 && !keep) begin
                pend[w]   = 1'b0;
                p_we[w]   = 1'($urandom_range(0, 1));
                p_addr[w] = $urandom;
                p_data[w] = $urandom;
            end
            @(negedge clk);
            if (k == 1) begin
                own = m1_gnt ? 1 : 0;
                check("gnt_winner", {m0_gnt, m1_gnt}, (w == 0) ? 64'd2 : 64'd1);
            end else begin
                check("gnt_once", {m0_gnt, m1_gnt}, 64'd0);
            end
            check("acc_io_we", 64'(io_we), 64'(t_we & io_ready));
            check("acc_io_addr", {io_addr, io_data}, {t_addr, t_data});
            check("acc_no_done", {m0_done, m1_done, err}, 64'd0);
            last = io_ready || (k == TIMEOUT);
        end

        @(posedge clk);
        #1;
        io_ready = 1'b0;
        @(negedge clk);
        if (to)        exp_rd[w] = '0;
        else if (!t_we) exp_rd[w] = rd_of(t_addr);
        check("done_who", {m0_done, m1_done}, (w == 0) ? 64'd2 : 64'd1);
        check("done_err", 64'(err), 64'(to));
        check("done_rdata0", 64'(m0_rdata), 64'(exp_rd[0]));
        check("done_rdata1", 64'(m1_rdata), 64'(exp_rd[1]));
        check("done_io_idle", {io_we, io_addr, io_data}, 64'd0);
        o_err      = err;
        o_rd       = own ? m1_rdata : m0_rdata;
        last_own_m = w;
        done_cyc   = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [31:0] a, input logic [31:0] d);
        pend[r]   = 1'b1;
        p_we[r]   = we;
        p_addr[r] = a;
        p_data[r] = d;
    endtask

    typedef struct {
        bit          new0;
        bit          new1;
        logic        we0;
        logic        we1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] data0;
        logic [31:0] data1;
        int          stall;
        int          exp_own;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          own;
        int          prev_own;
        int          prev_done;
        logic        o_err;
        logic [31:0] o_rd;

        vt[0] = '{1, 0, 1, 0, 32'hFFFF_FC60, 32'h0, 32'h0012_3456, 32'h0, 0, 0, 1'b0, 32'h0};
        vt[1] = '{0, 1, 0, 0, 32'h0, 32'hFFFF_FC70, 32'h0, 32'h0, 0, 1, 1'b0, 32'h0000_00A5};
        vt[2] = '{1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 2, 0, 1'b0, 32'h0010_FFEF};
        vt[3] = '{1, 0, 1, 0, 32'h20, 32'h0, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0, 32'h0010_FFEF};
        vt[4] = '{1, 0, 1, 0, 32'h30, 32'h0, 32'h1111_2222, 32'h0, 8, 0, 1'b1, 32'h0};
        vt[5] = '{1, 1, 0, 0, 32'h40, 32'h50, 32'h0, 32'h0, 0, 1, 1'b0, 32'h0050_FFAF};
        vt[6] = '{0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1'b0, 32'h0040_FFBF};
        vt[7] = '{1, 0, 0, 0, 32'hFFFF_FC70, 32'h0, 32'h0, 32'h0, 7, 0, 1'b0, 32'h0000_00A5};

        for (int r = 0; r < 2; r++) begin
            pend[r]   = 1'b0;
            p_we[r]   = 1'b0;
            p_addr[r] = '0;
            p_data[r] = '0;
            exp_rd[r] = '0;
        end
        io_ready   = 1'b0;
        last_own_m = 1;
        stall      = 0;
        rst        = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_gnt_done", {m0_gnt, m1_gnt, m0_done, m1_done, err}, 64'd0);
        check("rst_io", {io_we, io_addr, io_data}, 64'd0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            if (vt[i].new0) set_req(0, vt[i].we0, vt[i].addr0, vt[i].data0);
            if (vt[i].new1) set_req(1, vt[i].we1, vt[i].addr1, vt[i].data1);
            stall = vt[i].stall;
            serve_one(1'b0, own, o_err, o_rd);
            check($sformatf("vec%0d_owner", i), 64'(own), 64'(vt[i].exp_own));
            check($sformatf("vec%0d_err", i), 64'(o_err), 64'(vt[i].exp_err));
            check($sformatf("vec%0d_rdata", i), 64'(o_rd), 64'(vt[i].exp_rd));
        end

        // Both requesters hold req continuously: grants alternate, dones 3 cycles apart.
        set_req(0, 1'b0, 32'h60, 32'h0);
        set_req(1, 1'b1, 32'h70, 32'hCAFE_0001);
        stall = 0;
        serve_one(1'b1, prev_own, o_err, o_rd);
        prev_done = done_cyc;
        for (int i = 0; i < 4; i++) begin
            serve_one(1'b1, own, o_err, o_rd);
            check("rr_alternate", 64'(own), 64'(1 - prev_own));
            check("rr_spacing", 64'(done_cyc - prev_done), 64'd3);
            prev_own  = own;
            prev_done = done_cyc;
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a stalled write: no done, no strobe, tie goes to m0 afterwards.
        set_req(0, 1'b1, 32'h100, 32'h55);
        io_ready = 1'b0;
        @(posedge clk);
        #1 pend[0] = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_pulses", {m0_gnt, m1_gnt, m0_done, m1_done, err}, 64'd0);
        check("midrst_io", {io_we, io_addr, io_data}, 64'd0);
        check("midrst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        exp_q.delete();
        exp_rd[0]  = '0;
        exp_rd[1]  = '0;
        last_own_m = 1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_quiet", {m0_done, m1_done, m0_gnt, m1_gnt, io_we}, 64'd0);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 32'h200, 32'h0);
        set_req(1, 1'b0, 32'h300, 32'h0);
        stall = 0;
        serve_one(1'b0, own, o_err, o_rd);
        check("post_rst_tie_m0", 64'(own), 64'd0);
        serve_one(1'b0, own, o_err, o_rd);
        check("post_rst_then_m1", 64'(own), 64'd1);

        // Randomized transactions against the model.
        for (int i = 0; i < 150; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0) begin
                    set_req(r, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FC70 : $urandom, $urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                @(posedge clk);
                #1;
                continue;
            end
            stall = ($urandom_range(0, 7) == 0) ? TIMEOUT + $urandom_range(0, 1) : $urandom_range(0, 4);
            serve_one(1'b0, own, o_err, o_rd);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        repeat (2) @(posedge clk);
        check("write_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
